// File: rtl/serial_link_pkg.sv
// Shared serial-link types: packet header fields and credit-count sizing helper.
package serial_link_pkg;

  localparam int unsigned MaxCredW = 16;

  typedef struct packed {
    logic [MaxCredW-1:0] credits;
    logic                cred_only;
  } link_hdr_t;

  // Bits needed to count 0..num_credits inclusive.
  function automatic int unsigned cred_width(input int unsigned num_credits);
    return $clog2(num_credits + 1);
  endfunction

endpackage

// File: rtl/serial_link_rx_fifo.sv
// Ring buffer of arbitrary depth (not restricted to powers of two); no fall-through.
module serial_link_rx_fifo #(
  parameter type         data_t = logic,
  parameter type         cnt_t  = logic,
  parameter int unsigned Depth  = 2
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  push_i,
  input  data_t data_i,
  input  logic  pop_i,
  output data_t data_o,
  output logic  empty_o,
  output logic  full_o,
  output cnt_t  fill_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  data_t           mem_q [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  cnt_t            fill_q, fill_d;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (fill_q == '0);
  assign full_o  = (fill_q == cnt_t'(Depth));
  assign fill_o  = fill_q;
  // A pop frees the head slot in the same edge, so a full FIFO may still take a push.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rptr_q];

  always_comb begin
    wptr_d = do_push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = do_pop  ? ptr_inc(rptr_q) : rptr_q;
    fill_d = fill_q;
    if (do_push && !do_pop) begin
      fill_d = fill_q + cnt_t'(1);
    end else if (!do_push && do_pop) begin
      fill_d = fill_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fill_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      fill_q <= fill_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/serial_link_credit_rx_buffer.sv
// Receive-side credit companion: forwards returned credits, buffers payloads and
// produces one credit-release strobe per cycle toward the synchronization unit.
module serial_link_credit_rx_buffer
  import serial_link_pkg::*;
#(
  parameter type  data_t          = logic,
  parameter type  credit_t        = logic,
  parameter int   NumCredits      = -1,
  parameter logic CredOnlyPktMode = 1'b0
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  data_t   rx_data_i,
  input  credit_t rx_credits_i,
  input  logic    rx_cred_only_i,
  input  logic    rx_valid_i,
  output logic    rx_ready_o,
  output credit_t credits_received_o,
  output logic    receive_cred_o,
  output data_t   data_o,
  output logic    valid_o,
  input  logic    ready_i,
  output logic    release_o,
  output credit_t fill_o,
  output logic    overflow_o
);

  localparam int unsigned Depth = (NumCredits < 2) ? 32'd2 : unsigned'(NumCredits);

  link_hdr_t hdr;
  credit_t   cred_q, cred_d;
  logic      rcv_q, rcv_d;
  credit_t   pend_q, pend_d;
  logic      ovf_q;
  logic      push, pop, full, empty, ovf_evt;
  logic      pend_inc, pend_dec;

  assign hdr = '{credits: MaxCredW'(rx_credits_i), cred_only: rx_cred_only_i};

  assign rx_ready_o = 1'b1;
  assign push       = rx_valid_i & ~hdr.cred_only;
  assign valid_o    = ~empty;
  assign pop        = valid_o & ready_i;
  assign ovf_evt    = push & full & ~pop;

  serial_link_rx_fifo #(
    .data_t (data_t),
    .cnt_t  (credit_t),
    .Depth  (Depth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (rx_data_i),
    .pop_i   (pop),
    .data_o  (data_o),
    .empty_o (empty),
    .full_o  (full),
    .fill_o  (fill_o)
  );

  // Credit forwarding ignores FIFO state entirely, overflow included.
  assign rcv_d = rx_valid_i & (hdr.credits != '0);
  assign cred_d = rcv_d ? rx_credits_i : cred_q;

  // Pops own the release strobe; pending credits drain only in pop-free cycles.
  assign pend_inc  = rx_valid_i & hdr.cred_only & ~CredOnlyPktMode;
  assign pend_dec  = (pend_q != '0) & ~pop;
  assign release_o = pop | (pend_q != '0);

  always_comb begin
    pend_d = pend_q;
    if (pend_inc && !pend_dec) begin
      pend_d = pend_q + credit_t'(1);
    end else if (!pend_inc && pend_dec) begin
      pend_d = pend_q - credit_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cred_q <= '0;
      rcv_q  <= 1'b0;
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      cred_q <= cred_d;
      rcv_q  <= rcv_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_q | ovf_evt;
    end
  end

  assign credits_received_o = cred_q;
  assign receive_cred_o     = rcv_q;
  assign overflow_o         = ovf_q;

  a_params: assert property (@(posedge clk_i)
    (NumCredits >= 2) && ($bits(credit_t) >= cred_width(NumCredits)))
    else $error("NumCredits must be >= 2 and credit_t must hold 0..NumCredits");

  a_credit_budget: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (int'(fill_o) + int'(pend_q)) <= NumCredits)
    else $error("buffered payloads plus pending releases exceed NumCredits");

  a_pending_sat: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !((pend_q == credit_t'(NumCredits)) && pend_inc && !pend_dec))
    else $error("pending release counter incremented beyond NumCredits");

  c_overflow: cover property (@(posedge clk_i) disable iff (!rst_ni) ovf_evt);

endmodule

// File: tb/tb_serial_link_credit_rx_buffer.sv
// Randomised and directed scoreboard bench for serial_link_credit_rx_buffer.
module tb_serial_link_credit_rx_buffer;

  localparam int N = 5;
  typedef logic [7:0] data_t;
  typedef logic [2:0] cred_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_t rx_data;
  cred_t rx_cred;
  logic  rx_co, rx_v, ready;
  logic  rdy0, rc0, v0, rel0, ov0;
  cred_t cr0, fill0;
  data_t d0;

  data_t rx_data1;
  cred_t rx_cred1;
  logic  rx_co1, rx_v1, ready1;
  logic  rdy1, rc1, v1, rel1, ov1;
  cred_t cr1, fill1;
  data_t d1;

  serial_link_credit_rx_buffer #(
    .data_t(data_t), .credit_t(cred_t), .NumCredits(N), .CredOnlyPktMode(1'b0)
  ) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .rx_data_i(rx_data), .rx_credits_i(rx_cred),
    .rx_cred_only_i(rx_co), .rx_valid_i(rx_v), .rx_ready_o(rdy0),
    .credits_received_o(cr0), .receive_cred_o(rc0), .data_o(d0), .valid_o(v0),
    .ready_i(ready), .release_o(rel0), .fill_o(fill0), .overflow_o(ov0)
  );

  serial_link_credit_rx_buffer #(
    .data_t(data_t), .credit_t(cred_t), .NumCredits(N), .CredOnlyPktMode(1'b1)
  ) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .rx_data_i(rx_data1), .rx_credits_i(rx_cred1),
    .rx_cred_only_i(rx_co1), .rx_valid_i(rx_v1), .rx_ready_o(rdy1),
    .credits_received_o(cr1), .receive_cred_o(rc1), .data_o(d1), .valid_o(v1),
    .ready_i(ready1), .release_o(rel1), .fill_o(fill1), .overflow_o(ov1)
  );

  int checks = 0;
  int fails = 0;
  int rel_cnt = 0;

  // Reference model state (post-edge view of the receiver)
  data_t exp_q[$];
  int    fill_m = 0;
  int    pend_m = 0;
  int    cred_m = 0;
  bit    rc_m = 1'b0;
  bit    ov_m = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    fill_m = 0;
    pend_m = 0;
    cred_m = 0;
    rc_m   = 1'b0;
    ov_m   = 1'b0;
  endtask

  // One clock cycle of stimulus on instance 0; the model advances at the edge.
  task automatic cyc(input bit v, input bit co, input data_t d, input cred_t c, input bit r);
    bit pop_now, push_now, dec;
    rx_v = v; rx_co = co; rx_data = d; rx_cred = c; ready = r;
    @(posedge clk);
    pop_now  = r && (fill_m > 0);
    push_now = v && !co;
    dec      = (pend_m > 0) && !pop_now;
    rc_m = v && (c != 0);
    if (rc_m) cred_m = c;
    if (push_now) begin
      if (fill_m < N || pop_now) begin
        exp_q.push_back(d);
        fill_m++;
      end else begin
        ov_m = 1'b1;
      end
    end
    if (pop_now) fill_m--;
    if (v && co) pend_m++;
    if (dec) pend_m--;
    #1;
  endtask

  // Monitor: compares instance 0 against the model every cycle, pops scoreboard on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("rx_ready", rdy0, 1);
        chk("valid", v0, fill_m > 0);
        chk("fill", fill0, fill_m);
        chk("receive_cred", rc0, rc_m);
        chk("credits_received", cr0, cred_m);
        chk("overflow", ov0, ov_m);
        chk("release", rel0, (ready && fill_m > 0) || (pend_m > 0));
        if (rel0) rel_cnt++;
        if (v0 && exp_q.size() > 0) begin
          chk("data", d0, exp_q[0]);
          if (ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit    rv, rco, rr;
    data_t rd;
    cred_t rc;
    int    guard;
    rx_v = 0; rx_co = 0; rx_data = '0; rx_cred = '0; ready = 0;
    rx_v1 = 0; rx_co1 = 0; rx_data1 = '0; rx_cred1 = '0; ready1 = 0;
    #2;
    chk("rst_valid", v0, 0);
    chk("rst_data", d0, 0);
    chk("rst_fill", fill0, 0);
    chk("rst_release", rel0, 0);
    chk("rst_overflow", ov0, 0);
    chk("rst_receive_cred", rc0, 0);
    chk("rst_credits", cr0, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Data packet with credits, then pop
    cyc(1, 0, 8'hA5, 3'd3, 0);
    chk("t1_receive_cred", rc0, 1);
    chk("t1_credits", cr0, 3);
    chk("t1_valid", v0, 1);
    chk("t1_data", d0, 8'hA5);
    chk("t1_fill", fill0, 1);
    rx_v = 0; ready = 1;
    #1 chk("t1_release", rel0, 1);
    cyc(0, 0, 8'h00, 3'd0, 1);
    chk("t1_fill_after_pop", fill0, 0);
    cyc(0, 0, 8'h00, 3'd0, 0);

    // Three credits-only packets with zero credits
    rel_cnt = 0;
    repeat (3) cyc(1, 1, 8'h00, 3'd0, 0);
    repeat (2) cyc(0, 0, 8'h00, 3'd0, 0);
    chk("credonly_release_count", rel_cnt, 3);

    // Pending of two held while the sink pops for four cycles
    for (int i = 0; i < 4; i++) cyc(1, 0, data_t'(8'h10 + i), 3'd0, 0);
    cyc(1, 1, 8'h00, 3'd1, 1);
    cyc(1, 1, 8'h00, 3'd0, 1);
    rel_cnt = 0;
    cyc(1, 0, 8'h20, 3'd0, 1);
    cyc(1, 0, 8'h21, 3'd0, 1);
    cyc(0, 0, 8'h00, 3'd0, 1);
    cyc(0, 0, 8'h00, 3'd0, 1);
    repeat (3) cyc(0, 0, 8'h00, 3'd0, 0);
    chk("pending_pop_release_count", rel_cnt, 6);

    // Fill to depth, push with pop while full, then overflow
    for (int i = 0; i < N; i++) cyc(1, 0, data_t'(8'h50 + i), 3'd0, 0);
    chk("full_fill", fill0, N);
    chk("full_no_overflow", ov0, 0);
    cyc(1, 0, 8'h66, 3'd0, 1);
    chk("full_push_pop_fill", fill0, N);
    cyc(1, 0, 8'h77, 3'd2, 0);
    chk("overflow_set", ov0, 1);
    chk("overflow_fill", fill0, N);
    chk("overflow_credit_fwd", cr0, 2);
    repeat (N) cyc(0, 0, 8'h00, 3'd0, 1);
    chk("overflow_drained", v0, 0);
    chk("overflow_sticky", ov0, 1);

    // Asynchronous reset with buffered data and a pending release
    for (int i = 0; i < 4; i++) cyc(1, 0, data_t'(8'h80 + i), 3'd0, 0);
    cyc(1, 1, 8'h00, 3'd0, 1);
    chk("pre_reset_fill", fill0, 3);
    rx_v = 0; ready = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", v0, 0);
    chk("async_release", rel0, 0);
    chk("async_fill", fill0, 0);
    chk("async_overflow", ov0, 0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("post_reset_empty", v0, 0);
    cyc(1, 0, 8'h3C, 3'd0, 0);
    chk("post_reset_valid", v0, 1);
    chk("post_reset_data", d0, 8'h3C);
    cyc(0, 0, 8'h00, 3'd0, 1);

    // Randomised traffic obeying the far side's credit budget
    for (int i = 0; i < 400; i++) begin
      rv  = ($urandom_range(0, 3) != 0) && (fill_m + pend_m < N);
      rco = ($urandom_range(0, 3) == 0);
      rd  = data_t'($urandom);
      rc  = cred_t'($urandom_range(0, 5));
      rr  = $urandom_range(0, 1);
      cyc(rv, rco, rd, rc, rr);
    end
    guard = 0;
    while ((fill_m > 0 || pend_m > 0) && guard < 50) begin
      cyc(0, 0, 8'h00, 3'd0, 1);
      guard++;
    end
    chk("random_drain_done", (fill_m == 0) && (pend_m == 0), 1);
    cyc(0, 0, 8'h00, 3'd0, 0);
    chk("random_final_release", rel0, 0);

    // Credits-only packet on the instance that does not return its credit
    rx_v1 = 1; rx_co1 = 1; rx_cred1 = 3'd2; ready1 = 0;
    @(posedge clk);
    #1;
    rx_v1 = 0; rx_co1 = 0; rx_cred1 = '0;
    chk("mode1_receive_cred", rc1, 1);
    chk("mode1_credits", cr1, 2);
    chk("mode1_release", rel1, 0);
    chk("mode1_fill", fill1, 0);
    @(posedge clk);
    #1;
    chk("mode1_strobe_off", rc1, 0);
    chk("mode1_credits_hold", cr1, 2);
    chk("mode1_release_late", rel1, 0);
    chk("mode1_no_overflow", ov1, 0);
    chk("mode1_rx_ready", rdy1, 1);
    chk("mode1_valid", v1, 0);
    chk("mode1_data", d1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/serial_link_credit_rx_buffer.md
Name: serial_link_credit_rx_buffer

Overview:
- Receive-side companion of the credit synchronization unit.
- Accepts decoded link packets, each carrying a data payload, a credits field and a credits-only flag.
- Extracts the returned credits and forwards them to the local synchronization unit, so they feed its credits_received_i and receive_cred_i inputs.
- Buffers valid payloads in a NumCredits-deep FIFO toward the data sink, and produces the single-bit release strobe that drives the unit's buffer_queue_out_val_i/rdy_i credit-return path.

Parameters:
- data_t, logic: payload type.
- credit_t, logic: credit count type; must hold 0..NumCredits.
- NumCredits, -1: FIFO depth. Must be ≥2; an init assertion fires otherwise.
- CredOnlyPktMode, 1'b0: set to 0 when the far side consumes a credit for credits-only packets; this block then returns that credit.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- rx_data_i  in  $bits(data_t)  packet payload.
- rx_credits_i  in  $bits(credit_t)  credits returned by the far side.
- rx_cred_only_i  in  1  packet carries no valid payload.
- rx_valid_i  in  1  packet valid.
- rx_ready_o  out  1  tied to 1; credit flow guarantees space.
- credits_received_o  out  $bits(credit_t)  registered credit value.
- receive_cred_o  out  1  one-cycle strobe; credits_received_o is valid.
- data_o  out  $bits(data_t)  FIFO head.
- valid_o  out  1  FIFO non-empty.
- ready_i  in  1  sink ready.
- release_o  out  1  one credit freed this cycle; connect to both buffer_queue_out_val_i and buffer_queue_out_rdy_i of the sync unit.
- fill_o  out  $bits(credit_t)  current FIFO occupancy.
- overflow_o  out  1  sticky error: push attempted while full without a pop.

Behaviour:
- Reset values: credits_received_o=0, receive_cred_o=0, valid_o=0, data_o=0, release_o=0, fill_o=0, overflow_o=0. Pending counter is 0 and FIFO pointers are 0.
- Reset mid-operation drops all buffered data and all pending releases.
- Accept: an accepted packet is rx_valid_i=1 in cycle t; rx_ready_o is always 1.
- Credit path:
  - If rx_credits_i≠0 at t, then in t+1 credits_received_o=rx_credits_i and receive_cred_o=1.
  - Otherwise receive_cred_o=0 in t+1 and credits_received_o holds its previous value.
  - This path is independent of FIFO state, including overflow.
- Push: at t when rx_cred_only_i=0. No fall-through: the payload is visible on data_o/valid_o from t+1 at the earliest.
- Pop: valid_o & ready_i. Head advances at the clock edge.
- FIFO pointer and fill arithmetic:
  - Read and write pointers wrap at NumCredits-1 → 0; NumCredits need not be a power of two.
  - fill_o = fill + push − pop.
  - Simultaneous push and pop leaves fill unchanged. This is legal when full (the pop frees the slot) and when fill=1.
  - Push while empty with no pop gives valid_o=1 next cycle.
- Overflow: push while fill=NumCredits and no pop. The payload is dropped, overflow_o is set and held until reset, and credits are still forwarded. An assertion flags this event.
- Pending-release counter, credit_t wide, in use only when CredOnlyPktMode=0:
  - Increments on each accepted credits-only packet.
  - When CredOnlyPktMode=1, credits-only packets never touch it.
- release_o (combinational, one per cycle max):
  - release_o = pop | (pending≠0).
  - A pop takes priority; pending decrements only in a cycle with no pop.
  - A cred-only accept in the same cycle as a pending decrement leaves pending unchanged.
  - Latency: a credits-only packet accepted at t can release at t+1 at the earliest.
- Invariant: fill + pending ≤ NumCredits at all times. Assert it.
- Boundary case: pending saturating at NumCredits with a further increment is a protocol violation; assert it, with no wrap required.

Decomposition:
- Add to serial_link_pkg: helper function cred_width(NumCredits) = $clog2(NumCredits+1).
- The packet header struct {credits, cred_only} belongs in serial_link_pkg, shared with the transmit-side framer.
- One sub-module: serial_link_rx_fifo, a non-power-of-two ring buffer with push/pop/fill/full/empty. The top level keeps the credit register, pending counter, release mux and error flag.

Test Plan:
- Reset, then a data packet with payload 0xA5 and credits=3 at t.
  → t+1: receive_cred_o=1, credits_received_o=3, valid_o=1, data_o=0xA5, fill_o=1.
  → Pop at t+1 → release_o=1 at t+1; fill_o=0 at t+2.
- NumCredits=5, push 5 payloads with ready_i=0.
  → fill_o=5, overflow_o=0.
  → 6th push with a simultaneous pop: accepted, fill_o stays 5.
  → 7th push without pop: overflow_o=1, FIFO contents unchanged.
- CredOnlyPktMode=0: three credits-only packets with credits=0 on consecutive cycles, no data.
  → receive_cred_o never asserts.
  → release_o=1 for three consecutive cycles starting at the cycle after the first packet; pending returns to 0.
- CredOnlyPktMode=0: pending=2 while the sink pops for 4 consecutive cycles.
  → release_o=1 for 6 consecutive cycles; pending drains only after the pops stop.
- CredOnlyPktMode=1: credits-only packet with credits=2.
  → receive_cred_o=1, credits_received_o=2; release_o stays 0.
- Assert rst_ni low mid-burst with fill_o=3, pending=1.
  → Asynchronously: valid_o=0, release_o=0, fill_o=0, overflow_o=0.
  → First push after release of reset appears one cycle later.
